// File: rtl/bram_arb_pkg.sv
// Shared types for the two-requester BRAM port arbiter: lock FSM state,
// response tag and the requester count.
package bram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bram_rsp_tag_pipe.sv
// Delay line that walks a {valid, id} tag alongside each BRAM read so the
// returning word can be steered back to the requester that issued it.
module bram_rsp_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [READ_LATENCY];

  // Reset empties the pipe, so reads in flight at reset never respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[READ_LATENCY-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with
// in-order read return and a per-requester lock that times out when idle.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          lock_timeout,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_din,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  output lock_state_t                   lock_state,
  output logic                          lock_owner
);

  // Handshake: a beat from requester r transfers on the rising edge where
  // req_valid[r] and req_ready[r] are both high; ready depends only on
  // req_valid, prio and lock state, and there is no response backpressure.

  localparam logic [15:0] IDLE_LAST = 16'(LOCK_TIMEOUT - 1);

  lock_state_t state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q;
  logic [15:0] idle_q;

  logic                  gnt_any, gnt_id, accept, timeout_hit;
  logic                  win_we, win_lock;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_din;
  logic                  last_we;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] last_din;
  tag_t                  tag_in, tag_out;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = prio_q;
    if (state_q == LOCKED) begin
      gnt_id  = owner_q;
      gnt_any = req_valid[owner_q];
    end else if (&req_valid) begin
      gnt_id  = prio_q;
      gnt_any = 1'b1;
    end else if (req_valid[0]) begin
      gnt_id  = 1'b0;
      gnt_any = 1'b1;
    end else if (req_valid[1]) begin
      gnt_id  = 1'b1;
      gnt_any = 1'b1;
    end
  end

  assign accept    = gnt_any & rst_n;
  assign req_ready = accept ? id_onehot(gnt_id) : '0;

  assign win_we   = req_we[gnt_id];
  assign win_lock = req_lock[gnt_id];
  assign win_addr = gnt_id ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]  : req_addr[0 +: ADDR_WIDTH];
  assign win_din  = gnt_id ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];

  // Only the owner can be granted while locked, so any accept is the owner's.
  // An owner beat in the expiry cycle wins over the timeout.
  assign timeout_hit = (state_q == LOCKED) && !accept && (idle_q >= IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FREE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      FREE: begin
        if (accept && win_lock) begin
          state_d = LOCKED;
          owner_d = gnt_id;
        end
      end
      LOCKED: begin
        if ((accept && !win_lock) || timeout_hit) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_comb begin
    lock_timeout = timeout_hit;
    lock_state   = state_q;
    lock_owner   = owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b0;
      idle_q    <= '0;
      last_we   <= 1'b0;
      last_addr <= '0;
      last_din  <= '0;
    end else begin
      if (accept && (state_q == FREE) && !win_lock) prio_q <= ~gnt_id;
      if ((state_q == FREE) || accept || timeout_hit) idle_q <= '0;
      else                                            idle_q <= idle_q + 16'd1;
      if (accept) begin
        last_we   <= win_we;
        last_addr <= win_addr;
        last_din  <= win_din;
      end
    end
  end

  // The BRAM samples the winner directly; when idle the port keeps its last value.
  assign bram_en   = accept;
  assign bram_we   = accept ? win_we   : last_we;
  assign bram_addr = accept ? win_addr : last_addr;
  assign bram_din  = accept ? win_din  : last_din;

  assign tag_in.valid = accept & ~win_we;
  assign tag_in.id    = gnt_id;

  bram_rsp_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign rsp_valid = tag_out.valid ? id_onehot(tag_out.id) : '0;
  assign rsp_data  = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a rule-level model checked every
// cycle plus hand-computed checks for reset, contention, RAW, lock and timeout.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int LT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, bram_din, bram_dout;
  logic            lock_timeout, bram_en, bram_we, lock_owner;
  logic [AW-1:0]   bram_addr;
  lock_state_t     lock_state;

  int n_tests = 0;
  int n_fail  = 0;

  bram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .lock_timeout(lock_timeout),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout),
    .lock_state(lock_state), .lock_owner(lock_owner)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- BRAM fixture (2-cycle latency, no_change on writes) ----
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] shadow [1024];
  logic [DW-1:0] rd0 = '0, rd1 = '0;

  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    return {32'hC0DE_0000, 22'h0, a};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = pre(AW'(i));
      shadow[i] = pre(AW'(i));
    end
  end

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         rd0 <= mem[bram_addr];
    end
    rd1 <= rd0;
  end
  assign bram_dout = rd1;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: rule-level arbitration state plus a queue of promised responses.
  logic [DW:0]   exp_q[$];
  int            due_q[$];
  int            cyc = 0;
  bit            m_locked = 0, m_owner = 0, m_prio = 0;
  int            m_idle = 0;
  logic          m_lwe = 1'b0;
  logic [AW-1:0] m_laddr = '0;
  logic [DW-1:0] m_ldin = '0;

  always @(negedge clk) begin
    bit            has, w;
    int            wi;
    logic [1:0]    e_rsp;
    logic [DW-1:0] e_data;
    logic          e_to;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cyc++;
    if (!rst_n) begin
      m_locked = 0; m_owner = 0; m_prio = 0; m_idle = 0;
      m_lwe = 1'b0; m_laddr = '0; m_ldin = '0;
      exp_q.delete(); due_q.delete();
      check("m_rst_ready", req_ready, 0);
      check("m_rst_en", bram_en, 0);
      check("m_rst_rsp", rsp_valid, 0);
      check("m_rst_to", lock_timeout, 0);
      check("m_rst_addr", bram_addr, 0);
      check("m_rst_din", bram_din, 0);
      check("m_rst_we", bram_we, 0);
    end else begin
      has = 0; w = 0;
      if (m_locked) begin
        has = req_valid[m_owner]; w = m_owner;
      end else if (req_valid == 2'b11) begin
        has = 1; w = m_prio;
      end else if (req_valid != 2'b00) begin
        has = 1; w = req_valid[1];
      end
      wi = int'(w);
      a  = req_addr[wi*AW +: AW];
      d  = req_wdata[wi*DW +: DW];
      e_to = m_locked && !has && (m_idle + 1 == LT);

      e_rsp = 2'b00; e_data = '0;
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        e_rsp  = exp_q[0][DW] ? 2'b10 : 2'b01;
        e_data = exp_q[0][DW-1:0];
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end

      check("m_ready", req_ready, has ? (2'b01 << wi) : 2'b00);
      check("m_en", bram_en, has);
      check("m_we", bram_we, has ? req_we[wi] : m_lwe);
      check("m_addr", bram_addr, has ? a : m_laddr);
      check("m_din", bram_din, has ? d : m_ldin);
      check("m_rsp_valid", rsp_valid, e_rsp);
      if (e_rsp != 2'b00) check("m_rsp_data", rsp_data, e_data);
      check("m_timeout", lock_timeout, e_to);
      check("m_lock_state", lock_state, m_locked ? LOCKED : FREE);
      if (m_locked) check("m_lock_owner", lock_owner, m_owner);

      if (has) begin
        m_lwe = req_we[wi]; m_laddr = a; m_ldin = d;
        if (req_we[wi]) shadow[a] = d;
        else begin
          exp_q.push_back({w, shadow[a]});
          due_q.push_back(cyc + RL);
        end
        if (m_locked) begin
          m_idle = 0;
          if (!req_lock[wi]) m_locked = 0;
        end else if (req_lock[wi]) begin
          m_locked = 1; m_owner = w; m_idle = 0;
        end else begin
          m_prio = !w;
        end
      end else if (m_locked) begin
        if (e_to) begin
          m_locked = 0; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    req_valid[r]           = v;
    req_we[r]              = we;
    req_lock[r]            = lk;
    req_addr[r*AW +: AW]   = ad;
    req_wdata[r*DW +: DW]  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int pulse_k, grant_k, seen0, to_seen;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;

    // Reset with both requesters asking.
    set_req(0, 1, 0, 0, 10'h010, '0);
    set_req(1, 1, 0, 0, 10'h020, '0);
    repeat (3) tick();
    at_neg();
    check("rst_ready", req_ready, 2'b00);
    check("rst_en", bram_en, 0);
    tick();
    rst_n = 1'b1;

    // Contention: strict alternation starting with requester 0.
    for (int i = 0; i < 8; i++) begin
      at_neg();
      check("rr_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 2) begin
        check("rr_rsp0_valid", rsp_valid, 2'b01);
        check("rr_rsp0_data", rsp_data, 64'hC0DE0000_00000010);
      end
      if (i == 3) begin
        check("rr_rsp1_valid", rsp_valid, 2'b10);
        check("rr_rsp1_data", rsp_data, 64'hC0DE0000_00000020);
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Write then read the same address.
    set_req(0, 1, 1, 0, 10'h005, 64'hDEADBEEF);
    at_neg(); check("wr_grant", req_ready, 2'b01); tick();
    set_req(0, 1, 0, 0, 10'h005, '0);
    at_neg(); check("rd_grant", req_ready, 2'b01); tick();
    req_valid = '0;
    at_neg(); check("raw_early", rsp_valid, 2'b00); tick();
    at_neg();
    check("raw_valid", rsp_valid, 2'b01);
    check("raw_data", rsp_data, 64'hDEADBEEF);
    tick();
    at_neg(); check("raw_once", rsp_valid, 2'b00); tick();

    // Lock RMW by requester 1 while requester 0 waits.
    req_valid[0] = 1'b0;
    set_req(1, 1, 0, 1, 10'h007, '0);
    at_neg(); check("lk_acquire", req_ready, 2'b10); tick();
    set_req(1, 0, 0, 0, 10'h007, '0);
    set_req(0, 1, 0, 0, 10'h030, '0);
    for (int i = 0; i < 2; i++) begin
      at_neg(); check("lk_block", req_ready, 2'b00); tick();
    end
    set_req(1, 1, 1, 0, 10'h007, 64'h1234_5678);
    at_neg();
    check("lk_release", req_ready, 2'b10);
    check("lk_no_pulse", lock_timeout, 0);
    tick();
    req_valid[1] = 1'b0;
    at_neg(); check("lk_after", req_ready, 2'b01); tick();
    req_valid = '0;
    repeat (3) tick();

    // Lock timeout: requester 1 locks then goes idle.
    set_req(1, 1, 0, 1, 10'h008, '0);
    at_neg(); check("to_acquire", req_ready, 2'b10); tick();
    req_valid[1] = 1'b0;
    set_req(0, 1, 0, 0, 10'h031, '0);
    pulse_k = -1; grant_k = -1;
    for (int k = 1; k <= 7; k++) begin
      at_neg();
      if (lock_timeout && pulse_k < 0) pulse_k = k;
      if (req_ready[0] && grant_k < 0) grant_k = k;
      tick();
    end
    check("to_pulse_cycle", pulse_k, 4);
    check("to_grant_cycle", grant_k, 5);
    req_valid = '0;
    repeat (3) tick();

    // Reset one cycle after a locked read: no response, lock silently dropped.
    req_valid[1] = 1'b0;
    set_req(0, 1, 0, 1, 10'h00A, '0);
    at_neg(); check("mr_accept", req_ready, 2'b01); tick();
    req_valid = '0;
    rst_n = 1'b0;
    seen0 = 0; to_seen = 0;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      if (rsp_valid[0]) seen0++;
      if (lock_timeout) to_seen++;
      tick();
    end
    rst_n = 1'b1;
    set_req(1, 1, 0, 0, 10'h00B, '0);
    at_neg();
    check("mr_other_grant", req_ready, 2'b10);
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      if (rsp_valid[0]) seen0++;
      if (lock_timeout) to_seen++;
      tick();
    end
    check("mr_no_rsp", seen0, 0);
    check("mr_no_pulse", to_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
